// File: rtl/spi_pkg.sv
// Shared FSM encoding and bit-order constants for the arbitrated SPI master.
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DONE  = 3'd4,
    ST_GAP   = 3'd5
  } spi_state_e;

  localparam logic MSB_FIRST = 1'b1;
  localparam logic LSB_FIRST = 1'b0;

endpackage

// File: rtl/spi_arb_master_if.sv
// Requester handshake plus SPI pins of spi_arb_master; master = DUT side.
interface spi_arb_master_if;

  logic [1:0]  req;
  logic [1:0]  req_mlb;
  logic [15:0] req_tdata;
  logic [1:0]  gnt;
  logic        done;
  logic [7:0]  rdata;
  logic        ss;
  logic        sck;
  logic        mosi;
  logic        miso;

  modport master (
    input  req, req_mlb, req_tdata, miso,
    output gnt, done, rdata, ss, sck, mosi
  );

  modport slave (
    output req, req_mlb, req_tdata, miso,
    input  gnt, done, rdata, ss, sck, mosi
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: on a tie the requester not granted last wins.
module rr_arb2 (
  input  logic       clk,
  input  logic       rstb,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] gnt
);

  // last_q = index of the most recently granted requester
  logic last_q;
  logic last_d;

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = last_q ? 2'b01 : 2'b10;
    end
  end

  always_comb begin
    last_d = last_q;
    if (update && (gnt != 2'b00)) begin
      last_d = gnt[1];
    end
  end

  // Reset to "1 was last" so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/spi_arb_master.sv
// Two-requester SPI mode-3 master: round-robin grant, one byte per transaction,
// per-requester bit order; sck, ss and mosi all come straight from flops.
module spi_arb_master
  import spi_pkg::*;
#(
  parameter int unsigned DIV = 2,
  parameter int unsigned GAP = 2
) (
  input logic              clk,
  input logic              rstb,
  spi_arb_master_if.master bus
);

  localparam logic [7:0] DIV_LAST = 8'(DIV - 1);
  localparam logic [7:0] GAP_LAST = (GAP > 0) ? 8'(GAP - 1) : 8'd0;

  spi_state_e state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] tx_q, tx_d;
  logic [7:0] rx_q, rx_d;
  logic       mlb_q, mlb_d;
  logic [1:0] gnt_q, gnt_d;
  logic       ss_q, ss_d;
  logic       sck_q, sck_d;
  logic       mosi_q, mosi_d;
  logic       done_q, done_d;
  logic [7:0] rdata_q, rdata_d;

  logic [1:0] arb_gnt;
  logic       arb_update;
  logic       tx_bit;
  logic [7:0] tx_shift;
  logic [7:0] rx_shift;
  logic [7:0] req_byte [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_req_byte
    assign req_byte[gi] = bus.req_tdata[8*gi +: 8];
  end

  rr_arb2 u_arb (
    .clk    (clk),
    .rstb   (rstb),
    .req    (bus.req),
    .update (arb_update),
    .gnt    (arb_gnt)
  );

  always_comb begin
    if (mlb_q == MSB_FIRST) begin
      tx_bit   = tx_q[7];
      tx_shift = {tx_q[6:0], 1'b0};
      rx_shift = {rx_q[6:0], bus.miso};
    end else begin
      tx_bit   = tx_q[0];
      tx_shift = {1'b0, tx_q[7:1]};
      rx_shift = {bus.miso, rx_q[7:1]};
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_cnt_d  = bit_cnt_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    mlb_d      = mlb_q;
    gnt_d      = gnt_q;
    ss_d       = ss_q;
    sck_d      = sck_q;
    mosi_d     = mosi_q;
    done_d     = 1'b0;
    rdata_d    = rdata_q;
    arb_update = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.req != 2'b00) begin
          state_d    = ST_SETUP;
          cnt_d      = 8'd0;
          bit_cnt_d  = 3'd0;
          rx_d       = 8'd0;
          gnt_d      = arb_gnt;
          arb_update = 1'b1;
          ss_d       = 1'b0;
          sck_d      = 1'b1;
          mosi_d     = 1'b1;
          tx_d       = req_byte[arb_gnt[1]];
          mlb_d      = bus.req_mlb[arb_gnt[1]];
        end
      end

      ST_SETUP: begin
        if (cnt_q == DIV_LAST) begin
          // Entering SHIFT is the first falling sck edge: present bit 0 now.
          state_d = ST_SHIFT;
          cnt_d   = 8'd0;
          sck_d   = 1'b0;
          mosi_d  = tx_bit;
          tx_d    = tx_shift;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      ST_SHIFT: begin
        if (cnt_q != DIV_LAST) begin
          cnt_d = cnt_q + 8'd1;
        end else begin
          cnt_d = 8'd0;
          if (!sck_q) begin
            sck_d     = 1'b1;
            rx_d      = rx_shift;
            bit_cnt_d = bit_cnt_q + 3'd1;
          end else if (bit_cnt_q == 3'd0) begin
            // Counter wrapped: the 8th high phase just ended.
            state_d = ST_HOLD;
          end else begin
            sck_d  = 1'b0;
            mosi_d = tx_bit;
            tx_d   = tx_shift;
          end
        end
      end

      ST_HOLD: begin
        if (cnt_q == DIV_LAST) begin
          state_d = ST_DONE;
          cnt_d   = 8'd0;
          ss_d    = 1'b1;
          gnt_d   = 2'b00;
          done_d  = 1'b1;
          rdata_d = rx_q;
          mosi_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      ST_DONE: begin
        cnt_d   = 8'd0;
        state_d = (GAP == 0) ? ST_IDLE : ST_GAP;
      end

      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 8'd0;
      bit_cnt_q <= 3'd0;
      tx_q      <= 8'd0;
      rx_q      <= 8'd0;
      mlb_q     <= MSB_FIRST;
      gnt_q     <= 2'b00;
      ss_q      <= 1'b1;
      sck_q     <= 1'b1;
      mosi_q    <= 1'b1;
      done_q    <= 1'b0;
      rdata_q   <= 8'h00;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      mlb_q     <= mlb_d;
      gnt_q     <= gnt_d;
      ss_q      <= ss_d;
      sck_q     <= sck_d;
      mosi_q    <= mosi_d;
      done_q    <= done_d;
      rdata_q   <= rdata_d;
    end
  end

  assign bus.gnt   = gnt_q;
  assign bus.done  = done_q;
  assign bus.rdata = rdata_q;
  assign bus.ss    = ss_q;
  assign bus.sck   = sck_q;
  assign bus.mosi  = mosi_q;

endmodule
